// File: rtl/trng_bit_collector.sv
// TRNG consumer: alternates the source-select mux, synchronizes and samples its output,
// whitens the stream with a von Neumann corrector, packs bits into words and hands them off.
module trng_bit_collector #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SAMPLE_DIV  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             rnd_in,
    output logic             src_sel,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } pair_state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DIV_W-1:0]       div_q;
    pair_state_e            state_q;
    logic                   first_q;
    logic [WIDTH-1:0]       sr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sr_full_q;

    logic                   s_c;
    logic                   strobe_c;
    logic                   emit_c;
    logic                   free_c;
    logic [WIDTH-1:0]       sr_next_c;

    always_comb begin
        s_c       = sync_q[SYNC_STAGES-1];
        strobe_c  = ena && (div_q == DIV_LAST);
        emit_c    = strobe_c && (state_q == HAVE_FIRST) && (s_c != first_q);
        free_c    = !valid || ready;
        sr_next_c = {sr_q[WIDTH-2:0], first_q};
    end

    // Metastability filter on the asynchronous mux output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rnd_in};
        end
    end

    // Sample-strobe divider, frozen while collection is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (ena) begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // Pair FSM: both bits of a pair come from one source; switch source after each pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            src_sel <= 1'b0;
        end else if (!ena) begin
            state_q <= IDLE;
        end else if (strobe_c) begin
            case (state_q)
                IDLE: begin
                    first_q <= s_c;
                    state_q <= HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    src_sel <= ~src_sel;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Packing and output holding register; a parked full word blocks new bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            sr_full_q <= 1'b0;
            data      <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (valid && ready) begin
                valid <= 1'b0;
            end
            if (sr_full_q) begin
                if (emit_c) begin
                    overrun <= 1'b1;
                end
                if (free_c) begin
                    data      <= sr_q;
                    valid     <= 1'b1;
                    sr_full_q <= 1'b0;
                    cnt_q     <= '0;
                end
            end else if (emit_c) begin
                sr_q <= sr_next_c;
                if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    if (free_c) begin
                        data  <= sr_next_c;
                        valid <= 1'b1;
                    end else begin
                        sr_full_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_trng_bit_collector.sv
// Directed bench for trng_bit_collector: table-driven word vectors plus multi-cycle corner sequences.
module tb_trng_bit_collector;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SAMPLE_DIV  = 4;
    localparam int unsigned SYNC_STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             rnd_in;
    logic             src_sel;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;

    trng_bit_collector #(
        .WIDTH      (WIDTH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .rnd_in (rnd_in),
        .src_sel(src_sel),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pairs are 2-bit codes packed MSB-first: code {first, second}
    typedef struct {
        int unsigned n_pairs;
        logic [31:0] pairs;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        ena    = 1'b1;
        ready  = 1'b0;
        rnd_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One sample period: bit settles through the synchronizer before the next strobe
    task automatic feed_bit(input logic b);
        rnd_in = b;
        repeat (SAMPLE_DIV) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed_pairs(input logic [31:0] pairs, input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0] p;
            p = pairs[31-2*i -: 2];
            feed_bit(p[1]);
            feed_bit(p[0]);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b0;
        ready  = 1'b0;
        rnd_in = 1'b0;

        vecs[0] = '{8,  32'h9A59_0000, 1'b1, 8'hB2};
        vecs[1] = '{12, 32'hB4AD_4900, 1'b1, 8'hB2};
        vecs[2] = '{8,  32'hAAAA_0000, 1'b1, 8'hFF};
        vecs[3] = '{8,  32'h5555_0000, 1'b1, 8'h00};
        vecs[4] = '{8,  32'h6666_0000, 1'b1, 8'h55};
        vecs[5] = '{8,  32'hAAAB_0000, 1'b0, 8'h00};
        vecs[6] = '{16, 32'hFF00_95A9, 1'b1, 8'h8E};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_data",    32'(data),    32'd0);
        check("rst_src_sel", 32'(src_sel), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Constant input: no corrected bits, source alternates every pair
        do_reset();
        ready  = 1'b1;
        rnd_in = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("const_src_sel", 32'(src_sel), 32'((n / 8) % 2));
            check("const_valid",   32'(valid),   32'd0);
            check("const_overrun", 32'(overrun), 32'd0);
        end

        // Table-driven words
        for (int v = 0; v < 7; v++) begin
            do_reset();
            feed_pairs(vecs[v].pairs, int'(vecs[v].n_pairs));
            check($sformatf("vec%0d_valid", v),   32'(valid),   32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data", v),    32'(data),    32'(vecs[v].exp_data));
            check($sformatf("vec%0d_src_sel", v), 32'(src_sel), 32'(vecs[v].n_pairs % 2));
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_hold", v),    32'(data),    32'(vecs[v].exp_data));
            ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ready = 1'b0;
            check($sformatf("vec%0d_drain", v),   32'(valid),   32'd0);
        end

        // Backpressure: second word parks, 17th bit overruns
        do_reset();
        feed_pairs(32'h9A59_0000, 8);
        check("bp_w1_valid",   32'(valid),   32'd1);
        check("bp_w1_data",    32'(data),    32'hB2);
        feed_pairs(32'h6699_0000, 8);
        check("bp_w2_data",    32'(data),    32'hB2);
        check("bp_w2_overrun", 32'(overrun), 32'd0);
        feed_pairs(32'h8000_0000, 1);
        check("bp_ovr",        32'(overrun), 32'd1);
        check("bp_ovr_data",   32'(data),    32'hB2);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_next_valid", 32'(valid),   32'd1);
        check("bp_next_data",  32'(data),    32'h5A);
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        check("bp_empty",      32'(valid),   32'd0);
        check("bp_sticky",     32'(overrun), 32'd1);

        // ena drop mid-pair discards the stored first bit
        do_reset();
        feed_pairs(32'h8000_0000, 1);
        feed_bit(1'b1);
        ena = 1'b0;
        for (int n = 0; n < 20; n++) begin
            rnd_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check("ena_src_hold", 32'(src_sel), 32'd1);
        end
        ena = 1'b1;
        feed_pairs(32'h5554_0000, 7);
        check("ena_valid",   32'(valid),   32'd1);
        check("ena_data",    32'(data),    32'h80);
        check("ena_src_sel", 32'(src_sel), 32'd0);

        // Asynchronous reset between edges
        do_reset();
        feed_pairs(32'h9A59_6699, 16);
        feed_pairs(32'h8000_0000, 1);
        check("ar_pre_valid",   32'(valid),   32'd1);
        check("ar_pre_overrun", 32'(overrun), 32'd1);
        check("ar_pre_src_sel", 32'(src_sel), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid",   32'(valid),   32'd0);
        check("ar_data",    32'(data),    32'd0);
        check("ar_src_sel", 32'(src_sel), 32'd0);
        check("ar_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        feed_pairs(32'hAAA8_0000, 7);
        check("ar_partial_valid", 32'(valid), 32'd0);
        feed_pairs(32'h4000_0000, 1);
        check("ar_word_valid", 32'(valid), 32'd1);
        check("ar_word_data",  32'(data),  32'hFE);
        ready = 1'b0;

        // Transfer and new-word load on the same edge
        do_reset();
        feed_pairs(32'h9A59_0000, 8);
        check("same_w1_data", 32'(data), 32'hB2);
        feed_pairs(32'h6699_0000, 7);
        feed_bit(1'b0);
        rnd_in = 1'b1;
        repeat (SAMPLE_DIV - 1) @(posedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        check("same_valid",   32'(valid),   32'd1);
        check("same_data",    32'(data),    32'h5A);
        check("same_overrun", 32'(overrun), 32'd0);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready = 1'b0;
        check("same_drain",   32'(valid),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_bit_collector.md
Name: trng_bit_collector

Overview:
- Consumer end of the TRNG source-select mux.
- Drives the mux Select line, alternating between the two oscillator sources, and samples the asynchronous mux output through a synchronizer.
- Removes bias with a von Neumann corrector and packs the corrected bits into WIDTH-bit words.
- Delivers each word over a valid/ready handshake to the downstream readout logic.

Parameters:
- WIDTH, 8: output word width in bits; must be >=2.
- SAMPLE_DIV, 4: clocks between sample strobes; must be >= SYNC_STAGES+2.
- SYNC_STAGES, 2: synchronizer flop depth on rnd_in; must be >=2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  collection enable.
- rnd_in  input  1  asynchronous random bit from the mux Y output.
- src_sel  output  1  drives mux Select; 0 selects I0, 1 selects I1.
- data  output  WIDTH  collected random word.
- valid  output  1  data holds an unconsumed word.
- ready  input  1  consumer accepts data.
- overrun  output  1  sticky flag: a corrected bit was dropped.

Behaviour:
- Reset: asynchronous, active-low, takes effect without a clock edge. Clears synchronizer, divider, pair state, shift register, bit count, sr_full, data, valid, src_sel and overrun to 0. Reset mid-operation discards all partial state.
- Synchronizer: SYNC_STAGES flops on rnd_in. The last stage is the sampled bit s.
- Divider: counter runs 0..SAMPLE_DIV-1 while ena=1 and holds while ena=0. A strobe fires in the cycle the counter equals SAMPLE_DIV-1, and the counter wraps to 0.
- Pair FSM, two states:
  - IDLE: on strobe, store s as f and go to HAVE_FIRST.
  - HAVE_FIRST: on strobe, if s!=f emit corrected bit f (pair 10 gives 1, pair 01 gives 0); if s==f discard. In both cases toggle src_sel and return to IDLE.
  - Both bits of a pair come from the same source. src_sel toggles only at the end of a pair.
- ena=0: FSM forced to IDLE, so a partial pair is discarded. src_sel, shift register and bit count hold. The output handshake keeps operating.
- Packing:
  - Each emitted bit shifts in at the LSB: sr <= {sr[WIDTH-2:0], bit}, and the count increments. The first bit ends up at data MSB.
  - On the WIDTH-th bit, if the holding register is free (valid=0, or valid=1 and ready=1 in that cycle): data <= {sr[WIDTH-2:0], bit}, valid=1, count=0, with zero extra latency.
  - Otherwise the completed word stays in sr with sr_full=1.
- While sr_full=1:
  - At the first cycle the holding register is free, data <= sr, valid=1, sr_full=0, count=0.
  - Any bit emitted while sr_full=1 is dropped and sets overrun=1.
  - overrun clears only on reset.
- Handshake:
  - A transfer occurs when valid=1 and ready=1 on a clock edge.
  - data is stable while valid=1 and ready=0.
  - valid falls after a transfer unless a new word loads in the same cycle, in which case valid stays 1 with the new data.
- Bit emission occurs at most once per 2*SAMPLE_DIV cycles, so a load and an emission never conflict beyond the cases above.

Test Plan:
- Hold rnd_in=1, ena=1, ready=1 for 200 cycles -> valid never asserts, overrun=0, src_sel toggles every 8 cycles starting with the first pair end.
- Bench changes rnd_in only 1 cycle after each strobe, with 8 pairs 10,01,10,10,01,01,10,01 -> exactly one word, data=0xB2, valid=1 until ready. Insert 11 and 00 pairs between them -> same 0xB2.
- ready=0, feed 17 differing pairs -> first word held unchanged on data, second word in sr, 17th bit sets overrun=1. Raise ready -> first word transfers; next cycle data = second word, valid=1.
- ena=1 for the first strobe of a pair (rnd_in=1), then ena=0 for 20 cycles, then resume with pairs 01 -> the stored 1 is discarded, word bits reflect only post-resume pairs, and src_sel does not toggle during ena=0.
- Pull rst_n low mid-word between clock edges -> valid, data, src_sel, overrun go to 0 immediately. After release, a fresh 8 pairs are needed for the next word.
- valid=1, ready=1 in the cycle the 8th bit of the next word is emitted -> old word transfers, new word on data next edge with valid staying 1, overrun=0.
